// File: rtl/axi4_stream_pkt_pkg.sv
// rtl/axi4_stream_pkt_pkg.sv - shared types for the stream packetizer
package axi4_stream_pkt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pkt_state_t;

  // Input side is open only while a packet may still be in progress.
  function automatic logic st_active(input pkt_state_t s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/axi4_stream_pkt_if.sv
// rtl/axi4_stream_pkt_if.sv - stream bundle with source/sink modports
interface axi4_stream_pkt_if #(
  parameter int DN = 1,
  parameter int DW = 16
);
  logic [DN*DW-1:0] tdata;
  logic [DN-1:0]    tkeep;
  logic             tlast;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axi4_stream_skid.sv
// rtl/axi4_stream_skid.sv - 2-entry registered buffer; head entry drives the output
module axi4_stream_skid #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);
  logic [1:0]   r_cnt;
  logic [W-1:0] r_buf0;
  logic [W-1:0] r_buf1;
  logic         w_push;
  logic         w_pop;

  // Ready depends only on the fill level, never on the downstream ready.
  assign o_ready = (r_cnt != 2'd2);
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_buf0;
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= 2'd0;
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else if (i_clr) begin
      r_cnt  <= 2'd0;
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_buf0 <= i_data;
          else               r_buf1 <= i_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_buf0 <= i_data;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/axi4_stream_pkt.sv
// rtl/axi4_stream_pkt.sv - frames a continuous stream into fixed-length packets with a quota
module axi4_stream_pkt
  import axi4_stream_pkt_pkg::*;
#(
  parameter int DN = 1,
  parameter int DW = 16,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ctl_rst,
  input  logic          ctl_ena,
  input  logic [CW-1:0] cfg_len,
  input  logic [CW-1:0] cfg_num,
  output logic          sts_run,
  output logic [CW-1:0] sts_beat,
  output logic [CW-1:0] sts_pkt,
  axi4_stream_pkt_if.slave  sti,
  axi4_stream_pkt_if.master sto
);
  localparam int PW = DN*DW + DN + 1;
  localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};

  pkt_state_t    r_state;
  logic [CW-1:0] r_len;
  logic [CW-1:0] r_num;
  logic [CW-1:0] r_beat;
  logic [CW-1:0] r_pkt;

  logic          w_skid_rdy;
  logic          w_acc;
  logic          w_last;
  logic          w_quota;
  logic [CW-1:0] w_pkt_inc;
  logic [PW-1:0] w_out;

  assign sts_run    = st_active(r_state);
  assign sts_beat   = r_beat;
  assign sts_pkt    = r_pkt;
  assign sti.tready = st_active(r_state) & w_skid_rdy;

  assign w_acc     = sti.tvalid & sti.tready;
  assign w_last    = sti.tlast | ((r_len != '0) && (r_beat == r_len - C_ONE));
  assign w_pkt_inc = r_pkt + C_ONE;
  assign w_quota   = (r_num != '0) && (w_pkt_inc == r_num);

  // TLAST is decided at acceptance and travels with the beat through the buffer.
  axi4_stream_skid #(.W(PW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (ctl_rst),
    .i_data  ({sti.tdata, sti.tkeep, w_last}),
    .i_valid (w_acc),
    .o_ready (w_skid_rdy),
    .o_data  (w_out),
    .o_valid (sto.tvalid),
    .i_ready (sto.tready)
  );

  assign {sto.tdata, sto.tkeep, sto.tlast} = w_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_num   <= '0;
      r_beat  <= '0;
      r_pkt   <= '0;
    end else if (ctl_rst) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_num   <= '0;
      r_beat  <= '0;
      r_pkt   <= '0;
    end else begin
      if (w_acc) begin
        if (w_last) begin
          r_beat <= '0;
          r_pkt  <= w_pkt_inc;
        end else begin
          r_beat <= r_beat + C_ONE;
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (ctl_ena) begin
            r_state <= ST_RUN;
            r_len   <= cfg_len;
            r_num   <= cfg_num;
            r_beat  <= '0;
            r_pkt   <= '0;
          end
        end
        ST_RUN: begin
          // A beat accepted while enable drops still opens a packet that must be finished.
          if (w_acc && w_last && w_quota) begin
            r_state <= ST_DONE;
          end else if (!ctl_ena) begin
            if (w_acc && w_last)             r_state <= ST_IDLE;
            else if (w_acc || r_beat != '0)  r_state <= ST_DRAIN;
            else                             r_state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (w_acc && w_last) r_state <= ST_IDLE;
        end
        ST_DONE: begin
          if (!ctl_ena) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_stream_pkt.sv
// tb/tb_axi4_stream_pkt.sv - self-checking bench for the stream packetizer
module tb_axi4_stream_pkt;
  localparam int DN = 1;
  localparam int DW = 16;
  localparam int CW = 32;
  localparam int PW = DN*DW + DN + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ctl_rst = 1'b0;
  logic          ctl_ena = 1'b0;
  logic [CW-1:0] cfg_len = '0;
  logic [CW-1:0] cfg_num = '0;
  logic          sts_run;
  logic [CW-1:0] sts_beat;
  logic [CW-1:0] sts_pkt;

  axi4_stream_pkt_if #(.DN(DN), .DW(DW)) sti ();
  axi4_stream_pkt_if #(.DN(DN), .DW(DW)) sto ();

  always #5 clk = ~clk;

  axi4_stream_pkt #(.DN(DN), .DW(DW), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .ctl_rst  (ctl_rst),
    .ctl_ena  (ctl_ena),
    .cfg_len  (cfg_len),
    .cfg_num  (cfg_num),
    .sts_run  (sts_run),
    .sts_beat (sts_beat),
    .sts_pkt  (sts_pkt),
    .sti      (sti),
    .sto      (sto)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: counters straight from the framing rules plus an expected-output queue.
  int unsigned   m_len, m_num, m_beat, m_pkt;
  int unsigned   n_acc, n_out, n_last, seq;
  logic          m_chk = 1'b0;
  logic [PW-1:0] exp_q[$];

  typedef struct {
    int unsigned len, num, offer, tlast_at;
    int unsigned acc, pkt, lasts, beat;
    logic        rdy;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic l);
    sti.tvalid = v;
    sti.tdata  = seq[DN*DW-1:0];
    sti.tkeep  = {DN{seq[2]}};
    sti.tlast  = l;
  endtask

  task automatic tick();
    logic          acc, pop, hold, last;
    logic [PW-1:0] held, e;
    acc  = sti.tvalid & sti.tready;
    pop  = sto.tvalid & sto.tready;
    hold = sto.tvalid & ~sto.tready;
    held = {sto.tdata, sto.tkeep, sto.tlast};
    if (m_num != 0 && m_pkt == m_num) check("quota_ready", sti.tready, 0);
    if (acc) begin
      last = sti.tlast | (m_len != 0 && m_beat == m_len - 1);
      exp_q.push_back({sti.tdata, sti.tkeep, last});
      n_acc++;
      if (last) begin
        m_beat = 0;
        m_pkt++;
      end else begin
        m_beat++;
      end
    end
    if (pop) begin
      n_out++;
      if (sto.tlast) n_last++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_spurious: got %0h expected none", held);
      end else begin
        e = exp_q.pop_front();
        if (held !== e) begin
          bad++;
          $display("FAIL out_payload: got %0h expected %0h", held, e);
        end
      end
    end
    @(posedge clk);
    #1;
    if (hold) begin
      check("stall_valid", sto.tvalid, 1);
      check("stall_payload", {sto.tdata, sto.tkeep, sto.tlast}, held);
    end
    if (m_chk) begin
      check("sts_beat", sts_beat, m_beat);
      check("sts_pkt", sts_pkt, m_pkt);
    end
    if (acc) seq++;
  endtask

  task automatic start(input int unsigned len, input int unsigned num);
    ctl_ena = 1'b0;
    sti.tvalid = 1'b0;
    m_chk = 1'b0;
    ctl_rst = 1'b1;
    tick();
    ctl_rst = 1'b0;
    exp_q.delete();
    m_len = len; m_num = num; m_beat = 0; m_pkt = 0;
    n_acc = 0; n_out = 0; n_last = 0;
    cfg_len = len;
    cfg_num = num;
    ctl_ena = 1'b1;
    m_chk = 1'b1;
    tick();
  endtask

  task automatic drain();
    sti.tvalid = 1'b0;
    repeat (6) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic v;
    int unsigned a0;
    tbl[0] = '{4, 0, 12, 0, 12, 3, 3, 0, 1'b1};
    tbl[1] = '{4, 2, 20, 0,  8, 2, 2, 0, 1'b0};
    tbl[2] = '{8, 0, 11, 3, 11, 2, 2, 0, 1'b1};
    tbl[3] = '{1, 3, 10, 0,  3, 3, 3, 0, 1'b0};
    tbl[4] = '{0, 0,  7, 0,  7, 0, 0, 7, 1'b1};
    tbl[5] = '{0, 1, 10, 5,  5, 1, 1, 0, 1'b0};
    seq = 1;
    sto.tready = 1'b1;
    set_in(1'b0, 1'b0);

    #12;
    check("rst_tready", sti.tready, 0);
    check("rst_tvalid", sto.tvalid, 0);
    check("rst_run", sts_run, 0);
    check("rst_beat", sts_beat, 0);
    check("rst_pkt", sts_pkt, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      start(tbl[i].len, tbl[i].num);
      cfg_len = 7;
      cfg_num = 0;
      for (int c = 0; c < int'(tbl[i].offer) + 10 && n_acc < tbl[i].offer; c++) begin
        set_in(1'b1, n_acc + 1 == tbl[i].tlast_at);
        tick();
      end
      drain();
      check($sformatf("tbl%0d_acc", i), n_acc, tbl[i].acc);
      check($sformatf("tbl%0d_pkt", i), sts_pkt, tbl[i].pkt);
      check($sformatf("tbl%0d_lasts", i), n_last, tbl[i].lasts);
      check($sformatf("tbl%0d_beat", i), sts_beat, tbl[i].beat);
      check($sformatf("tbl%0d_rdy", i), sti.tready, tbl[i].rdy);
    end

    start(4, 0);
    set_in(1'b1, 1'b0);
    check("lat_before", sto.tvalid, 0);
    a0 = seq;
    tick();
    check("lat_valid", sto.tvalid, 1);
    check("lat_data", sto.tdata, a0[DN*DW-1:0]);
    drain();

    start(5, 0);
    for (int c = 0; c < 10 && n_acc < 2; c++) begin
      set_in(1'b1, 1'b0);
      tick();
    end
    ctl_ena = 1'b0;
    for (int c = 0; c < 10; c++) begin
      set_in(1'b1, 1'b0);
      tick();
      check("drop_run", sts_run, n_acc < 5);
    end
    drain();
    check("drop_acc", n_acc, 5);
    check("drop_lasts", n_last, 1);

    start(4, 0);
    for (int c = 0; c < 10 && n_acc < 2; c++) begin
      set_in(1'b1, 1'b0);
      tick();
    end
    rst = 1'b1;
    sti.tvalid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    m_chk = 1'b0;
    exp_q.delete();
    check("mid_rst_tready", sti.tready, 0);
    check("mid_rst_tvalid", sto.tvalid, 0);
    check("mid_rst_beat", sts_beat, 0);
    check("mid_rst_pkt", sts_pkt, 0);
    check("mid_rst_run", sts_run, 0);

    start(3, 0);
    v = 1'b0;
    for (int c = 0; c < 3000 && n_acc < 300; c++) begin
      if (!v) v = ($urandom_range(0, 3) != 0);
      set_in(v, 1'b0);
      sto.tready = $urandom_range(0, 1) == 1;
      a0 = n_acc;
      tick();
      if (n_acc != a0) v = ($urandom_range(0, 3) != 0);
    end
    sto.tready = 1'b1;
    drain();
    check("rand_budget", n_acc >= 300, 1);
    check("rand_count", n_out, n_acc);
    check("rand_lasts", n_last, n_acc / 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
